systolic_feeder: RTL
====================

// Module: systolic_feeder
// PURPOSE
//  Transmit side of the 4x4 systolic array's west/north operand streams. Holds a 4x4 A and
//  a 4x4 B operand bank and replays them as skewed wavefronts so the array computes A x B.
//  Row i of A drives the west edge of array row i, delayed i cycles; column j of B drives
//  the north edge of array column j, delayed j cycles. Zero padding is driven outside the
//  valid window. Sits between the host write path and the array inputs.
// PARAMETERS
//  DW            16  operand width; must match the array's 16-bit edge ports
//  FLUSH_CYCLES   3  zero cycles after the last wavefront, letting partial sums settle
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  wr_en        in   1   bank write strobe; honoured only when busy=0
//  wr_sel       in   1   0 = A bank, 1 = B bank
//  wr_addr      in   4   {row[1:0],col[1:0]}
//  wr_data      in   DW  operand word
//  start        in   1   one-cycle feed request; honoured only when busy=0
//  busy         out  1   high from start acceptance until feed_done
//  feed_valid   out  1   high while the out_* ports carry a wavefront
//  feed_done    out  1   one-cycle pulse at the end of the flush
//  arr_clr      out  1   array accumulator clear pulse (see CONFIGURATION)
//  out_west0/4/8/12  out DW  to array inp_west0/4/8/12 (rows 0..3)
//  out_north0..3     out DW  to array inp_north0..3 (columns 0..3)
// BEHAVIOUR
//  - Reset: busy, feed_valid, feed_done and arr_clr = 0. All out_* = 0. FSM = IDLE. Banks are
//    not cleared.
//  - FSM: IDLE -> FEED (t = 0..6) -> FLUSH (FLUSH_CYCLES cycles) -> IDLE.
//  - Edge E0 samples start=1 in IDLE: go to FEED, t=0, busy=1.
//  - Edges E1..E7 register wavefront k = t into the outputs, then t++.
//  - Wavefront k drives out_west(4i) = A[i][k-i] and out_north(j) = B[k-j][j] when the index
//    is 0..3, else 0.
//  - feed_valid = 1 after E1..E7.
//  - E8: outputs go to 0, feed_valid=0, FSM enters FLUSH.
//  - After FLUSH_CYCLES flush cycles (E8+FLUSH_CYCLES; E11 by default): feed_done=1 for one
//    cycle, busy=0, FSM returns to IDLE.
//  - A new start may be sampled in the same cycle that feed_done is high.
//  - Writes commit at the clock edge. A write and a start in the same IDLE cycle: the new
//    value appears in the feed, because the first wavefront is read one edge after E0.
//  - wr_en or start while busy=1 is silently ignored. Banks and timing are unaffected.
//  - Reset mid-feed: outputs drop to 0 immediately (asynchronous). FSM returns to IDLE with
//    no feed_done. Bank contents are kept.
//  - The block does no arithmetic: pure pass-through/zero mux, values unsigned or signed
//    as the array interprets them. t is a 3-bit counter and saturates in FLUSH.
// CONFIGURATION
//  ARRAY_CLR_EN defined:
//    - FSM becomes IDLE -> CLR -> FEED...
//    - CLR lasts one cycle with arr_clr=1 (registered, high after E0), clearing the array
//      accumulators.
//    - All later timing shifts by +1 edge: first wavefront at E2, feed_done at E12 by
//      default.
//  ARRAY_CLR_EN undefined:
//    - arr_clr is tied to 0.
//    - No CLR state; timing as above.
// STRUCTURE
//  - Shared package: DW, array dimension N=4, wavefront count 2N-1=7, FSM state encoding
//    (IDLE/CLR/FEED/FLUSH), wr_sel encodings.
//  - One sub-module, systolic_operand_bank: 16 x DW register file with a write port, plus a
//    combinational diagonal read. Given wavefront k, it returns 4 words, with zero where the
//    index is out of range.
//  - Instantiated twice: A read row-wise, B read column-wise. The FSM and output registers
//    stay in systolic_feeder.
// TESTING
//  1. Reset -> all out_*=0, busy=0, feed_valid=0, feed_done=0, arr_clr=0.
//  2. Load A[r][c]=16r+c+1 and B[r][c]=256+16r+c, then start:
//     - E1: out_west0=1, out_north0=256, other outputs 0.
//     - E2: out_west0=2, out_west4=17, out_north0=272, out_north1=257.
//     - E7: out_west12=52, out_north3=307, all other outputs 0.
//     - E8: all outputs 0.
//     - E11: feed_done=1, busy=0.
//  3. During a feed, write A[0][0]=0xFFFF and pulse start at E3 -> current sequence
//     unchanged, no second feed. A following feed shows out_west0=1 at E1.
//  4. In one IDLE cycle, wr_en A[0][0]=0x00AA together with start -> out_west0=0x00AA at E1.
//  5. Assert rst after E4 -> outputs 0 immediately, no feed_done. Next start replays the
//     full bank contents from scenario 2 unchanged.
//  6. ARRAY_CLR_EN build -> arr_clr=1 for exactly one cycle after E0, out_west0=1 at E2,
//     feed_done at E12.

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array operand feeder: array geometry,
// wavefront count, FSM state encoding and bank-select encodings.
package systolic_feeder_pkg;

    localparam int DATA_W = 16;
    localparam int N      = 4;
    localparam int NWAVE  = 2 * N - 1;
    localparam int TW     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_FEED  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // True when a diagonal index lands inside the 4x4 bank.
    function automatic logic idx_ok(input int idx);
        return (idx >= 0) && (idx < N);
    endfunction

endpackage

// File: rtl/systolic_operand_bank.sv
// 16-word operand register file with one write port and a combinational
// diagonal read. For wavefront k, lane i returns M[i][k-i] (row-wise read)
// or M[k-i][i] (column-wise read), zero when the index is out of range.
module systolic_operand_bank
    import systolic_feeder_pkg::*;
#(
    parameter int DW       = DATA_W,
    parameter bit COL_READ = 1'b0
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [3:0]             wr_addr,
    input  logic [DW-1:0]          wr_data,
    input  logic [TW-1:0]          rd_wave,
    output logic [N-1:0][DW-1:0]   rd_data
);

    logic [DW-1:0] mem [0:N*N-1];
    int            diag;

    // Storage is deliberately not reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Diagonal read with zero padding outside the valid window.
    always_comb begin
        rd_data = '0;
        diag    = 0;
        for (int i = 0; i < N; i++) begin
            diag = int'(rd_wave) - i;
            if (idx_ok(diag)) begin
                if (COL_READ) begin
                    rd_data[i] = mem[{2'(diag), 2'(i)}];
                end else begin
                    rd_data[i] = mem[{2'(i), 2'(diag)}];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the 4x4 systolic array: replays the A and B banks as
// skewed wavefronts onto the west/north array edges, then flushes with zeros.
// Optional feature macro: ARRAY_CLR_EN (adds a one-cycle accumulator clear
// state ahead of the feed; arr_clr is tied low otherwise).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; bank writes accepted
// ST_CLR   | one cycle with arr_clr high (ARRAY_CLR_EN builds only)
// ST_FEED  | t = 0..6 registers wavefront t; t = 7 zeroes outputs
// ST_FLUSH | zero cycles while partial sums settle, then feed_done
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int DW           = DATA_W,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [3:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          feed_valid,
    output logic          feed_done,
    output logic          arr_clr,
    output logic [DW-1:0] out_west0,
    output logic [DW-1:0] out_west4,
    output logic [DW-1:0] out_west8,
    output logic [DW-1:0] out_west12,
    output logic [DW-1:0] out_north0,
    output logic [DW-1:0] out_north1,
    output logic [DW-1:0] out_north2,
    output logic [DW-1:0] out_north3
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e                state_q, state_d;
    logic [TW-1:0]         t_q, t_d;
    logic [FCW-1:0]        fcnt_q, fcnt_d;
    logic [N-1:0][DW-1:0]  west_q, west_d, north_q, north_d;
    logic [N-1:0][DW-1:0]  a_wave, b_wave;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  idle;
    logic                  wr_a, wr_b;
`ifdef ARRAY_CLR_EN
    logic                  clr_q, clr_d;
`endif

    assign idle = (state_q == ST_IDLE);
    assign busy = !idle;
    assign wr_a = wr_en && idle && (wr_sel == SEL_A);
    assign wr_b = wr_en && idle && (wr_sel == SEL_B);

    systolic_operand_bank #(.DW(DW), .COL_READ(1'b0)) u_bank_a (
        .clk     (clk),
        .wr_en   (wr_a),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_wave (t_q),
        .rd_data (a_wave)
    );

    systolic_operand_bank #(.DW(DW), .COL_READ(1'b1)) u_bank_b (
        .clk     (clk),
        .wr_en   (wr_b),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_wave (t_q),
        .rd_data (b_wave)
    );

    // Next-state, wavefront counter, flush down-counter and registered outputs.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        fcnt_d  = fcnt_q;
        west_d  = '0;
        north_d = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
`ifdef ARRAY_CLR_EN
        clr_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    t_d = '0;
`ifdef ARRAY_CLR_EN
                    state_d = ST_CLR;
                    clr_d   = 1'b1;
`else
                    state_d = ST_FEED;
`endif
                end
            end
            ST_CLR: begin
                state_d = ST_FEED;
                t_d     = '0;
            end
            ST_FEED: begin
                if (t_q < TW'(NWAVE)) begin
                    west_d  = a_wave;
                    north_d = b_wave;
                    valid_d = 1'b1;
                    t_d     = t_q + TW'(1);
                end else begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FCW'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                // t stays parked at its terminal value here.
                if (fcnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    fcnt_d = fcnt_q - FCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops the edge ports to zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            fcnt_q  <= '0;
            west_q  <= '0;
            north_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            fcnt_q  <= fcnt_d;
            west_q  <= west_d;
            north_q <= north_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

`ifdef ARRAY_CLR_EN
    // Registered accumulator clear, high for the single CLR cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_q <= 1'b0;
        end else begin
            clr_q <= clr_d;
        end
    end
    assign arr_clr = clr_q;
`else
    assign arr_clr = 1'b0;
`endif

    assign feed_valid = valid_q;
    assign feed_done  = done_q;
    assign out_west0  = west_q[0];
    assign out_west4  = west_q[1];
    assign out_west8  = west_q[2];
    assign out_west12 = west_q[3];
    assign out_north0 = north_q[0];
    assign out_north1 = north_q[1];
    assign out_north2 = north_q[2];
    assign out_north3 = north_q[3];

endmodule
